// File: rtl/writeback_queue.sv
// Write-side companion of the register file: buffers retiring results in a small FIFO,
// drains one per cycle into the A3/WD3/WE3 port and forwards the youngest pending value.
module writeback_queue #(
  parameter int ADDR_Nbits = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  WritebackQueue_CLK,
  input  logic                  WritebackQueue_RST,
  input  logic                  WritebackQueue_IN_VALID,
  output logic                  WritebackQueue_IN_READY,
  input  logic [ADDR_Nbits-1:0] WritebackQueue_IN_ADDR,
  input  logic [DATA_WIDTH-1:0] WritebackQueue_IN_DATA,
  input  logic                  WritebackQueue_DRAIN_EN,
  output logic                  WritebackQueue_WE3,
  output logic [ADDR_Nbits-1:0] WritebackQueue_A3,
  output logic [DATA_WIDTH-1:0] WritebackQueue_WD3,
  input  logic [ADDR_Nbits-1:0] WritebackQueue_LK_A1,
  input  logic [ADDR_Nbits-1:0] WritebackQueue_LK_A2,
  output logic                  WritebackQueue_LK_HIT1,
  output logic                  WritebackQueue_LK_HIT2,
  output logic [DATA_WIDTH-1:0] WritebackQueue_LK_DATA1,
  output logic [DATA_WIDTH-1:0] WritebackQueue_LK_DATA2,
  output logic [PTR_W:0]        WritebackQueue_COUNT,
  output logic                  WritebackQueue_FULL,
  output logic                  WritebackQueue_EMPTY
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

  logic [ADDR_Nbits-1:0] addr_r  [DEPTH];
  logic [DATA_WIDTH-1:0] data_r  [DEPTH];
  logic [DEPTH-1:0]      valid_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W:0]        count_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  ready_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;

  logic [PTR_W-1:0]      ord_idx_s [DEPTH];
  logic [DEPTH-1:0]      match1_s;
  logic [DEPTH-1:0]      match2_s;
  logic                  hit1_s;
  logic                  hit2_s;
  logic [DATA_WIDTH-1:0] data1_s;
  logic [DATA_WIDTH-1:0] data2_s;

  assign full_s   = (count_r == CNT_DEPTH);
  assign empty_s  = (count_r == '0);
  assign ready_s  = !full_s && !WritebackQueue_RST;
  assign accept_s = WritebackQueue_IN_VALID && ready_s;
  // Writes to r0 finish the handshake but never occupy an entry.
  assign push_s   = accept_s && (WritebackQueue_IN_ADDR != '0);
  assign pop_s    = !empty_s && WritebackQueue_DRAIN_EN;

  // ord_idx_s[0] is the oldest entry, ord_idx_s[DEPTH-1] the youngest possible slot.
  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    assign ord_idx_s[k] = rd_ptr_r + PTR_W'(k);
    assign match1_s[k]  = valid_r[ord_idx_s[k]] && (addr_r[ord_idx_s[k]] == WritebackQueue_LK_A1)
                          && (WritebackQueue_LK_A1 != '0);
    assign match2_s[k]  = valid_r[ord_idx_s[k]] && (addr_r[ord_idx_s[k]] == WritebackQueue_LK_A2)
                          && (WritebackQueue_LK_A2 != '0);
  end

  // Youngest-match lookup: sweep oldest to youngest so later matches override earlier ones.
  always_comb begin
    hit1_s  = 1'b0;
    hit2_s  = 1'b0;
    data1_s = '0;
    data2_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit1_s  = hit1_s | match1_s[k];
      hit2_s  = hit2_s | match2_s[k];
      data1_s = match1_s[k] ? data_r[ord_idx_s[k]] : data1_s;
      data2_s = match2_s[k] ? data_r[ord_idx_s[k]] : data2_s;
    end
  end

  // Entry storage, valid bits and pointers.
  always_ff @(posedge WritebackQueue_CLK or posedge WritebackQueue_RST) begin
    if (WritebackQueue_RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      // Push and pop never target the same slot: that needs an empty or a full queue.
      if (push_s) begin
        addr_r[wr_ptr_r]  <= WritebackQueue_IN_ADDR;
        data_r[wr_ptr_r]  <= WritebackQueue_IN_DATA;
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r          <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge WritebackQueue_CLK or posedge WritebackQueue_RST) begin
    if (WritebackQueue_RST) begin
      count_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign WritebackQueue_IN_READY = ready_s;
  assign WritebackQueue_WE3      = pop_s;
  assign WritebackQueue_A3       = empty_s ? '0 : addr_r[rd_ptr_r];
  assign WritebackQueue_WD3      = empty_s ? '0 : data_r[rd_ptr_r];
  assign WritebackQueue_LK_HIT1  = hit1_s;
  assign WritebackQueue_LK_HIT2  = hit2_s;
  assign WritebackQueue_LK_DATA1 = data1_s;
  assign WritebackQueue_LK_DATA2 = data2_s;
  assign WritebackQueue_COUNT    = count_r;
  assign WritebackQueue_FULL     = full_s;
  assign WritebackQueue_EMPTY    = empty_s;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_queue;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] lk_a1;
  logic [AW-1:0] lk_a2;
  logic          hit1;
  logic          hit2;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [PW:0]   count;
  logic          full;
  logic          empty;

  writeback_queue #(.ADDR_Nbits(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .WritebackQueue_CLK(clk),           .WritebackQueue_RST(rst),
    .WritebackQueue_IN_VALID(in_valid), .WritebackQueue_IN_READY(in_ready),
    .WritebackQueue_IN_ADDR(in_addr),   .WritebackQueue_IN_DATA(in_data),
    .WritebackQueue_DRAIN_EN(drain_en), .WritebackQueue_WE3(we3),
    .WritebackQueue_A3(a3),             .WritebackQueue_WD3(wd3),
    .WritebackQueue_LK_A1(lk_a1),       .WritebackQueue_LK_A2(lk_a2),
    .WritebackQueue_LK_HIT1(hit1),      .WritebackQueue_LK_HIT2(hit2),
    .WritebackQueue_LK_DATA1(data1),    .WritebackQueue_LK_DATA2(data2),
    .WritebackQueue_COUNT(count),       .WritebackQueue_FULL(full),
    .WritebackQueue_EMPTY(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   n_err = 0;
  int   n_chk = 0;
  bit   acc_last = 1'b0;
  logic [AW-1:0] order [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to address a, as {hit, data}.
  function automatic logic [DW:0] ref_lookup(input logic [AW-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (a != '0 && q[i].a == a) return {1'b1, q[i].d};
    end
    return '0;
  endfunction

  task automatic check_outputs();
    logic [DW:0] l1;
    logic [DW:0] l2;
    int n;
    n  = q.size();
    l1 = ref_lookup(lk_a1);
    l2 = ref_lookup(lk_a2);
    chk("in_ready", 64'(in_ready), 64'(n < DEPTH && !rst));
    chk("we3",      64'(we3),      64'(n > 0 && drain_en && !rst));
    chk("a3",       64'(a3),       n > 0 ? 64'(q[0].a) : 64'd0);
    chk("wd3",      64'(wd3),      n > 0 ? 64'(q[0].d) : 64'd0);
    chk("count",    64'(count),    64'(n));
    chk("full",     64'(full),     64'(n == DEPTH));
    chk("empty",    64'(empty),    64'(n == 0));
    chk("hit1",     64'(hit1),     64'(l1[DW]));
    chk("data1",    64'(data1),    64'(l1[DW-1:0]));
    chk("hit2",     64'(hit2),     64'(l2[DW]));
    chk("data2",    64'(data2),    64'(l2[DW-1:0]));
  endtask

  // One clock: check outputs mid-low phase, advance the model at the edge, return at negedge.
  task automatic cycle();
    bit accept;
    bit pop;
    #1;
    check_outputs();
    accept = in_valid && (q.size() < DEPTH) && !rst;
    pop    = drain_en && (q.size() > 0) && !rst;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (accept && in_addr != '0) q.push_back('{a: in_addr, d: in_data});
    acc_last = accept;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b0; lk_a1 = '0; lk_a2 = '0;
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Single push into an empty queue, drained one edge later.
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF; drain_en = 1'b1;
    cycle();
    in_valid = 1'b0;
    #1;
    chk("t2_we3", 64'(we3), 64'd1);
    chk("t2_a3",  64'(a3),  64'd5);
    chk("t2_wd3", 64'(wd3), 64'hDEADBEEF);
    cycle();
    #1;
    chk("t2_empty", 64'(empty), 64'd1);
    cycle();

    // Fill to FULL with draining off, hold a fifth offer, then drain in order.
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = AW'(i); in_data = 32'h100 + 32'(i);
      cycle();
    end
    in_addr = 5'd9; in_data = 32'h999;
    cycle();
    #1;
    chk("t3_full",  64'(full),     64'd1);
    chk("t3_ready", 64'(in_ready), 64'd0);
    drain_en = 1'b1;
    order[0] = 5'd1; order[1] = 5'd2; order[2] = 5'd3; order[3] = 5'd4; order[4] = 5'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_order_a3", 64'(a3),  64'(order[i]));
      chk("t3_order_we", 64'(we3), 64'd1);
      cycle();
      if (i == 1) in_valid = 1'b0;
    end
    cycle();

    // r0 write: handshake completes, nothing enqueued, never visible.
    in_valid = 1'b1; in_addr = '0; in_data = 32'h1234; lk_a1 = '0;
    #1;
    chk("t4_ready", 64'(in_ready), 64'd1);
    chk("t4_hit1",  64'(hit1),     64'd0);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_we3",   64'(we3),   64'd0);
    cycle();

    // Duplicate address: youngest value is forwarded.
    drain_en = 1'b0;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h11;
    cycle();
    in_data = 32'h22;
    cycle();
    in_valid = 1'b0; lk_a1 = 5'd7; lk_a2 = 5'd8;
    #1;
    chk("t5_hit1",  64'(hit1),  64'd1);
    chk("t5_data1", 64'(data1), 64'h22);
    chk("t5_hit2",  64'(hit2),  64'd0);
    chk("t5_data2", 64'(data2), 64'd0);
    cycle();

    // Simultaneous push and pop at COUNT=2 for 8 cycles.
    drain_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = AW'(10 + i); in_data = $urandom;
      #1;
      chk("t6_count", 64'(count), 64'd2);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset with three pending entries.
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = AW'(20 + i); in_data = $urandom;
      cycle();
    end
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'h55; drain_en = 1'b1;
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check_outputs();
    chk("t1_ready", 64'(in_ready), 64'd0);
    chk("t1_count", 64'(count),    64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("t1_we3_after", 64'(we3), 64'd0);
    cycle();

    // Random traffic against the model; offers stay stable until accepted.
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !acc_last)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_addr  = AW'($urandom_range(0, 7));
        in_data  = $urandom;
      end
      drain_en = ($urandom_range(0, 3) != 0);
      lk_a1    = AW'($urandom_range(0, 7));
      lk_a2    = AW'($urandom_range(0, 7));
      cycle();
    end
    in_valid = 1'b0; drain_en = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
